// File: rtl/vga_scan_generator.sv
// Raster scan generator: pixel-rate divider, x/y timing counters, sync decode,
// pixel-tick delay chain for hsync/vsync/de, and line/frame markers.
module vga_scan_generator #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned PIPE_DELAY  = 1,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        pix_en,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active_pixel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  // Timing totals are summed at 32 bits and only then narrowed to the 10-bit counters.
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEGIN = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEGIN = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SIG_W    = 3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic             ACT_RST  = (H_ACTIVE > 0) && (V_ACTIVE > 0);
  // Delay-chain word is {hsync, vsync, de} already in output polarity.
  localparam logic [SIG_W-1:0] SIG_IDLE = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  // Reject timings the 10-bit counters cannot represent.
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (H_TOTAL == 0) || (V_TOTAL == 0)
      || (CLK_DIV < 1) || (PIPE_DELAY > 7)) begin : g_bad_params
    $error("vga_scan_generator: unsupported timing parameters");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             active_pixel_q, active_pixel_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             tick;
  logic             h_raw;
  logic             v_raw;
  logic             act_raw;
  logic [SIG_W-1:0] sig_raw;

  // Divider, counters and marker pulses.
  always_comb begin
    div_d          = div_q;
    pix_en_d       = 1'b0;
    x_d            = x_q;
    y_d            = y_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;
    frame_count_d  = frame_count_q;
    tick           = 1'b0;
    if (enable) begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : DIV_W'(div_q + 1'b1);
    end
    if (tick) begin
      pix_en_d = 1'b1;
      if (x_q == H_LAST) begin
        x_d          = '0;
        line_start_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          frame_count_d = 16'(frame_count_q + 16'd1);
        end else begin
          y_d = 10'(y_q + 10'd1);
        end
      end else begin
        x_d = 10'(x_q + 10'd1);
      end
    end
    // Registered alongside x/y so it always describes the current position.
    active_pixel_d = (x_d < 10'(H_ACTIVE)) && (y_d < 10'(V_ACTIVE));
  end

  // State register for divider, counters and markers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q          <= '0;
      pix_en_q       <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      active_pixel_q <= ACT_RST;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      div_q          <= div_d;
      pix_en_q       <= pix_en_d;
      x_q            <= x_d;
      y_q            <= y_d;
      active_pixel_q <= active_pixel_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  // Sync and data-enable decode from the undelayed counters.
  always_comb begin
    h_raw   = (x_q >= 10'(HS_BEGIN)) && (x_q < 10'(HS_END));
    v_raw   = (y_q >= 10'(VS_BEGIN)) && (y_q < 10'(VS_END));
    act_raw = (x_q < 10'(H_ACTIVE)) && (y_q < 10'(V_ACTIVE));
    sig_raw = {h_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE,
               v_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE,
               act_raw};
  end

  if (PIPE_DELAY == 0) begin : g_no_pipe
    // No pipeline latency to match: drive straight from the decode.
    assign hsync = sig_raw[2];
    assign vsync = sig_raw[1];
    assign de    = sig_raw[0];
  end else begin : g_pipe
    logic [SIG_W-1:0] pipe_q [PIPE_DELAY];
    logic [SIG_W-1:0] pipe_d [PIPE_DELAY];

    // Shift the decoded signals one stage per pixel tick.
    always_comb begin
      for (int i = 0; i < int'(PIPE_DELAY); i++) begin
        pipe_d[i] = pipe_q[i];
      end
      if (tick) begin
        pipe_d[0] = sig_raw;
        for (int i = 1; i < int'(PIPE_DELAY); i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    // Delay-chain registers, filled with idle levels on reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(PIPE_DELAY); i++) begin
          pipe_q[i] <= SIG_IDLE;
        end
      end else begin
        for (int i = 0; i < int'(PIPE_DELAY); i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end

    assign hsync = pipe_q[PIPE_DELAY-1][2];
    assign vsync = pipe_q[PIPE_DELAY-1][1];
    assign de    = pipe_q[PIPE_DELAY-1][0];
  end

  assign pix_en       = pix_en_q;
  assign x            = x_q;
  assign y            = y_q;
  assign active_pixel = active_pixel_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator using a reduced raster so whole frames stay short.
module tb_vga_scan_generator;

  localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int unsigned VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int unsigned DIV = 2, PD = 1;
  localparam logic        SA  = 1'b0;
  localparam int unsigned HT  = HA + HF + HS + HB;
  localparam int unsigned VT  = VA + VF + VS + VB;
  localparam int unsigned FT  = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        pix_en, active_pixel, de, hsync, vsync, line_start, frame_start;
  logic [9:0]  x, y;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;

  // Reference state: enabled clocks since reset, strobe flag, frame-count offset.
  int unsigned c_en = 0;
  bit          pe_m = 1'b0;
  logic [15:0] fc_base = '0;

  vga_scan_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV), .PIPE_DELAY(PD), .SYNC_ACTIVE(SA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_en(pix_en),
    .x(x), .y(y), .active_pixel(active_pixel), .de(de),
    .hsync(hsync), .vsync(vsync), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit h_on(input int unsigned m);
    int unsigned xm = m % HT;
    return (xm >= HA + HF) && (xm < HA + HF + HS);
  endfunction

  function automatic bit v_on(input int unsigned m);
    int unsigned ym = (m / HT) % VT;
    return (ym >= VA + VF) && (ym < VA + VF + VS);
  endfunction

  function automatic bit act_on(input int unsigned m);
    return ((m % HT) < HA) && (((m / HT) % VT) < VA);
  endfunction

  // Expected outputs follow from the number of pixel ticks since reset.
  task automatic compare_all();
    int unsigned n  = c_en / DIV;
    int unsigned ex = n % HT;
    int unsigned ey = (n / HT) % VT;
    logic [15:0] efc = 16'(fc_base + 16'(n / FT));
    logic        ehs = (n >= PD) ? (h_on(n - PD) ? SA : ~SA) : ~SA;
    logic        evs = (n >= PD) ? (v_on(n - PD) ? SA : ~SA) : ~SA;
    logic        ede = (n >= PD) ? act_on(n - PD) : 1'b0;
    chk("x", 32'(x), ex);
    chk("y", 32'(y), ey);
    chk("pix_en", 32'(pix_en), 32'(pe_m));
    chk("active_pixel", 32'(active_pixel), 32'(act_on(n)));
    chk("de", 32'(de), 32'(ede));
    chk("hsync", 32'(hsync), 32'(ehs));
    chk("vsync", 32'(vsync), 32'(evs));
    chk("line_start", 32'(line_start), 32'(pe_m && ex == 0));
    chk("frame_start", 32'(frame_start), 32'(pe_m && ex == 0 && ey == 0));
    chk("frame_count", 32'(frame_count), 32'(efc));
  endtask

  // One clock: advance the reference with the inputs seen at the edge, then check.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      c_en = 0; pe_m = 1'b0; fc_base = '0;
    end else if (enable) begin
      c_en++;
      pe_m = (c_en % DIV) == 0;
    end else begin
      pe_m = 1'b0;
    end
    #1;
    compare_all();
  endtask

  initial begin
    int          cnt_pe, cnt_hs, cnt_vs, cnt_de, guard;
    bit          hit;
    logic [9:0]  fx, fy;
    logic        fhs, fvs;

    // Reset held for three clocks.
    rst_n = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_de", 32'(de), 0);
    chk("rst_fc", 32'(frame_count), 0);

    // Release: strobe on clocks 2, 4, 6.
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("pix_en_phase", 32'(pix_en), 32'((i % 2) == 0));
    end

    // Wait for the first frame wrap.
    hit = 1'b0;
    for (int i = 0; i < int'(2 * FT * DIV + 10) && !hit; i++) begin
      step();
      hit = frame_start;
    end
    chk("first_frame_timeout", 32'(hit), 1);
    chk("wrap_xy", 32'({x, y}), 0);
    chk("wrap_fc", 32'(frame_count), 1);

    // Per-frame totals over one full frame.
    cnt_pe = 0; cnt_hs = 0; cnt_vs = 0; cnt_de = 0; hit = 1'b0; guard = 0;
    while (!hit && guard < int'(2 * FT * DIV + 10)) begin
      if (pix_en) begin
        cnt_pe++;
        if (hsync == SA) cnt_hs++;
        if (vsync == SA) cnt_vs++;
        if (de) cnt_de++;
      end
      step();
      guard++;
      hit = frame_start;
    end
    chk("frame_timeout", 32'(hit), 1);
    chk("ticks_per_frame", cnt_pe, FT);
    chk("hsync_ticks", cnt_hs, HS * VT);
    chk("vsync_ticks", cnt_vs, VS * HT);
    chk("de_ticks", cnt_de, HA * VA);

    // Random enable gating.
    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      step();
    end

    // Freeze mid-line and resume.
    enable = 1'b1; hit = 1'b0;
    for (int i = 0; i < int'(2 * FT * DIV + 10) && !hit; i++) begin
      step();
      hit = pix_en && x == 10'd10 && y == 10'd3;
    end
    chk("freeze_find", 32'(hit), 1);
    fx = x; fy = y; fhs = hsync; fvs = vsync;
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("freeze_x", 32'(x), 32'(fx));
      chk("freeze_y", 32'(y), 32'(fy));
      chk("freeze_pix_en", 32'(pix_en), 0);
      chk("freeze_sync", 32'({hsync, vsync}), 32'({fhs, fvs}));
    end
    enable = 1'b1; hit = 1'b0;
    for (int i = 0; i < int'(DIV + 2) && !hit; i++) begin
      step();
      hit = pix_en;
    end
    chk("resume_pix_en", 32'(hit), 1);
    chk("resume_x", 32'(x), 11);

    // Mid-frame reset.
    hit = 1'b0;
    for (int i = 0; i < int'(2 * FT * DIV + 10) && !hit; i++) begin
      step();
      hit = pix_en && x == 10'd20 && y == 10'd5;
    end
    chk("midreset_find", 32'(hit), 1);
    rst_n = 1'b0;
    step();
    chk("midreset_xy", 32'({x, y}), 0);
    chk("midreset_fc", 32'(frame_count), 0);
    chk("midreset_fs", 32'(frame_start), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Frame counter rollover.
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    fc_base = 16'(16'hFFFF - 16'((c_en / DIV) / FT));
    hit = 1'b0;
    for (int i = 0; i < int'(2 * FT * DIV + 10) && !hit; i++) begin
      step();
      hit = frame_start;
    end
    chk("rollover_fs", 32'(hit), 1);
    chk("rollover_fc", 32'(frame_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_scan_generator.md
Name: vga_scan_generator

Overview:
- Produces the raster scan that pixel renderers (tile and number-glyph display logic) consume: `x`, `y`, `active_pixel`, plus `hsync`/`vsync` for the VGA connector.
- Derives the pixel-rate strobe from the system clock and counts the horizontal and vertical timing.
- Delays the sync and data-enable outputs by a configurable number of pixel ticks, so they line up with renderer/ROM pipeline latency.
- Provides frame and line markers for game-state update logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)
- PIPE_DELAY, 1, pixel ticks of delay applied to hsync/vsync/de (0..7)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- enable  input  1  scan runs when high; counters freeze when low
- pix_en  output  1  one-clk pixel strobe
- x  output  10  current column counter
- y  output  10  current line counter
- active_pixel  output  1  (x < H_ACTIVE) && (y < V_ACTIVE), undelayed
- de  output  1  active_pixel delayed PIPE_DELAY pixel ticks
- hsync  output  1  horizontal sync, delayed PIPE_DELAY pixel ticks
- vsync  output  1  vertical sync, delayed PIPE_DELAY pixel ticks
- line_start  output  1  one-clk pulse after x wraps to 0
- frame_start  output  1  one-clk pulse after (x,y) wraps to (0,0)
- frame_count  output  16  completed-frame counter

Behaviour:
- One clock domain and one reset: synchronous, active-low. All state updates on posedge `clk`; `rst_n` sampled only at the edge.
- Reset values:
  - div counter = 0, `pix_en` = 0
  - `x` = `y` = 0
  - `de` = 0, `line_start` = 0, `frame_start` = 0, `frame_count` = 0
  - `hsync` = `vsync` = ~SYNC_ACTIVE; delay-chain stages filled with the inactive values.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525). Both must be <= 1024.
- Divider:
  - counts 0..CLK_DIV-1 while `enable` is high.
  - `pix_en` is registered: high for exactly one clk when the divider wraps. First `pix_en` arrives CLK_DIV clks after reset release.
  - CLK_DIV=1 means `pix_en` is constantly high while enabled.
- Counters advance only on `pix_en`:
  - x = H_TOTAL-1 -> x = 0 and y increments; otherwise x increments.
  - y = V_TOTAL-1 together with an x wrap -> y = 0 and `frame_count` increments (modulo 2^16, 65535 -> 0).
- Sync decode, from the undelayed counters:
  - h_raw is active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - v_raw is active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 490..491).
- Delay chain:
  - {h_raw, v_raw, active_pixel} pass through PIPE_DELAY registers that shift only on `pix_en`.
  - PIPE_DELAY=0 means outputs are the combinational decode of the counter registers.
  - Output polarity follows SYNC_ACTIVE.
- `line_start`: registered, high for one clk on the clk after an x wrap.
- `frame_start`: registered, high for one clk on the clk after the (x,y) -> (0,0) wrap. Neither pulse is asserted merely by reset.
- `enable` low:
  - divider, counters and delay chain hold their values.
  - `pix_en`, `line_start` and `frame_start` are forced to 0.
  - Re-asserting `enable` resumes exactly where the scan stopped.
- Reset mid-frame: all state returns to the reset values on the next edge. The new scan starts at (0,0) with no `frame_start` pulse and no `frame_count` increment.
- Width rule: all compares are done at 10 bits. Parameter sums must be evaluated at 32 bits, then checked to fit.

Test Plan:
- Reset -> hold `rst_n`=0 for 3 clks: `x`=`y`=0, `hsync`=`vsync`=1, `de`=0, `frame_count`=0. Release with CLK_DIV=2: `pix_en` pulses on clks 2, 4, 6... with a 1-clk width.
- Horizontal timing, defaults -> `hsync` low for exactly 96 pixel ticks, first low tick PIPE_DELAY(1) ticks after x=656. `de` high for 640 consecutive ticks per visible line.
- Line/frame wrap -> x goes 799 -> 0 and y increments. At (799,524) the counters go to (0,0), `frame_start` pulses for 1 clk, `frame_count` goes 0 -> 1. `vsync` is low only for lines 490..491, shifted by one tick. Exactly 420000 `pix_en` pulses occur per frame.
- Enable freeze -> deassert `enable` at x=300, y=10 for 50 clks: `x`, `y` and syncs are stable and no `pix_en` occurs. On resume the next `pix_en` gives x=301.
- Mid-frame reset -> assert `rst_n`=0 at (500,200): next clk `x`=`y`=0, `frame_count`=0, no `frame_start` pulse.
- Counter rollover -> force `frame_count`=65535, then complete a frame: `frame_count`=0 and `frame_start` is still asserted.
